// File: rtl/control_sequencer.sv
// Multi-cycle control unit for the bus-based datapath: fetch with memory-ready
// stall, opcode decode, and per-state strobe generation for execute.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            Cout,
  output logic [NREG-1:0] reg_out,
  output logic [NREG-1:0] reg_in,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            ZHighIn,
  output logic            ZLowIn,
  output logic            IncPC,
  output logic            Read,
  output logic [OPW-1:0]  alu_op,
  output logic            run,
  output logic            illegal
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0]      state, nxt;
  logic [4:0]      opc;
  logic [OPW-1:0]  opw;
  logic            is_rr, is_imm, is_md, is_un, is_mfhi, is_mflo, is_nop, is_halt, is_ill;
  logic [NREG-1:0] ra_oh, rb_oh, rc_oh;
  logic            unused_ir;

  assign opc       = ir[31:27];
  assign opw       = OPW'(opc);
  assign unused_ir = ^ir[14:0];

  assign is_rr   = (opc[4:3] == 2'b00);
  assign is_imm  = (opc == 5'd8) || (opc == 5'd9) || (opc == 5'd10);
  assign is_md   = (opc == 5'd15) || (opc == 5'd16);
  assign is_un   = (opc == 5'd17) || (opc == 5'd18);
  assign is_mfhi = (opc == 5'd24);
  assign is_mflo = (opc == 5'd25);
  assign is_nop  = (opc == 5'd26);
  assign is_halt = (opc == 5'd27);
  assign is_ill  = !(is_rr || is_imm || is_md || is_un || is_mfhi || is_mflo || is_nop || is_halt);

  // Register-field one-hot decode; fields wider than NREG simply never match.
  always_comb begin
    ra_oh = '0;
    rb_oh = '0;
    rc_oh = '0;
    for (int i = 0; i < NREG; i++) begin
      ra_oh[i] = (ir[26:23] == 4'(i));
      rb_oh[i] = (ir[22:19] == 4'(i));
      rc_oh[i] = (ir[18:15] == 4'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) state <= S_RST;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_RST:  nxt = S_T0;
      S_T0:   nxt = stop ? S_HALT : S_T1;
      S_T1:   nxt = mem_ready ? S_T2 : S_T1;
      S_T2:   nxt = S_T3;
      S_T3: begin
        if (is_rr || is_imm || is_md || is_un) nxt = S_T4;
        else if (is_halt)                      nxt = S_HALT;
        else                                   nxt = S_T0;
      end
      S_T4:   nxt = is_un ? S_T0 : S_T5;
      S_T5:   nxt = is_md ? S_T6 : S_T0;
      S_T6:   nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
    reg_out = '0; reg_in = '0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    alu_op = '0;
    illegal = 1'b0;
    run = (state != S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (is_rr || is_imm || is_md) begin
          reg_out = rb_oh; Yin = 1'b1;
        end else if (is_un) begin
          reg_out = rb_oh; alu_op = opw; ZLowIn = 1'b1;
        end else if (is_mfhi) begin
          HIout = 1'b1; reg_in = ra_oh;
        end else if (is_mflo) begin
          LOout = 1'b1; reg_in = ra_oh;
        end else if (is_ill) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        if (is_un) begin
          Zlowout = 1'b1; reg_in = ra_oh;
        end else begin
          // Immediate forms take the sign-extended constant off the bus instead of Rc.
          if (is_imm) Cout = 1'b1;
          else        reg_out = rc_oh;
          alu_op  = opw;
          ZLowIn  = 1'b1;
          ZHighIn = is_md;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md) LOin = 1'b1;
        else       reg_in = ra_oh;
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
